// File: rtl/seq_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential 16-op ALU with valid/ready handshake. Shifts and
//               rotates move one bit per cycle, unless SEQ_ALU_BARREL_EN is
//               defined, in which case they finish in one cycle through a
//               combinational barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [1:0]       kind;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   amt;
    logic             go_shift;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_val;
    logic             step_c;

    assign amt       = b[SHW-1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

`ifdef SEQ_ALU_BARREL_EN
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] rotl_v;
    logic [WIDTH-1:0] rotr_v;
    logic [WIDTH-1:0] barrel_res;
    logic             barrel_c;

    assign go_shift = 1'b0;

    // One-cycle barrel shift; the extra bit of each extended vector is the last bit shifted out
    always_comb begin
        shl_ext = {1'b0, a} << amt;
        shr_ext = {a, 1'b0} >> amt;
        for (int i = 0; i < WIDTH; i++) begin
            rotl_v[i] = a[SHW'(i - int'(amt))];
            rotr_v[i] = a[SHW'(i + int'(amt))];
        end
        barrel_res = a;
        barrel_c   = 1'b0;
        case (op[1:0])
            2'd0: begin barrel_res = shl_ext[WIDTH-1:0]; barrel_c = shl_ext[WIDTH]; end
            2'd1: begin barrel_res = shr_ext[WIDTH:1];   barrel_c = shr_ext[0];     end
            2'd2: begin barrel_res = rotl_v; barrel_c = (amt != '0) && rotl_v[0];       end
            2'd3: begin barrel_res = rotr_v; barrel_c = (amt != '0) && rotr_v[WIDTH-1]; end
            default: ;
        endcase
    end
`else
    // Serial mode: a shift with a nonzero amount goes through the SHIFT state
    assign go_shift = (op[3:2] == 2'b01) && (amt != '0);
`endif

    // Single-cycle result and flags for everything decided at accept time
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            4'h1: alu_res = b;
            4'h2: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'h3: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'h4, 4'h5, 4'h6, 4'h7: begin
`ifdef SEQ_ALU_BARREL_EN
                alu_res = barrel_res;
                alu_c   = barrel_c;
`else
                // Only reached with amount 0: operand passes through, carry stays 0
                alu_res = a;
`endif
            end
            4'h8: alu_res = a & b;
            4'h9: alu_res = a | b;
            4'hA: alu_res = a ^ b;
            4'hB: alu_res = ~(a | b);
            4'hC: alu_res = ~(a & b);
            4'hD: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'hE: alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
            4'hF: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            default: ;
        endcase
    end

    // One-bit step of the serial shifter, with the bit that leaves the word
    always_comb begin
        step_val = work;
        step_c   = 1'b0;
        case (kind)
            2'd0: begin step_val = {work[WIDTH-2:0], 1'b0};        step_c = work[WIDTH-1]; end
            2'd1: begin step_val = {1'b0, work[WIDTH-1:1]};        step_c = work[0];       end
            2'd2: begin step_val = {work[WIDTH-2:0], work[WIDTH-1]}; step_c = work[WIDTH-1]; end
            2'd3: begin step_val = {work[0], work[WIDTH-1:1]};     step_c = work[0];       end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; SHIFT ends on the edge that performs the last bit step
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = go_shift ? SHIFT : DONE;
            SHIFT:   if (cnt == SHW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, step while shifting, hold everywhere else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            flags  <= '0;
            work   <= '0;
            kind   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (go_shift) begin
                            work <= a;
                            kind <= op[1:0];
                            cnt  <= amt;
                        end else begin
                            result <= alu_res;
                            flags  <= {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
                        end
                    end
                end
                SHIFT: begin
                    work <= step_val;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result <= step_val;
                        flags  <= {1'b0, step_c, step_val[WIDTH-1], (step_val == '0)};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (WIDTH=16). A transaction-level
//               model predicts handshake, latency, result and flags each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] result;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

`ifdef SEQ_ALU_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    seq_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Reference ALU from the operation definitions, using plain integer arithmetic
    function automatic void model(input int o, input int x, input int y,
                                  output int r, output int f);
        int n, c, v, s;
        n = y & 15; c = 0; v = 0; r = 0;
        case (o)
            1:  r = y;
            2:  begin s = x + y; r = s & 'hFFFF; c = s >> 16;
                      s = sgn(x) + sgn(y); v = (s > 32767 || s < -32768); end
            3:  begin r = (x - y) & 'hFFFF; c = (x < y);
                      s = sgn(x) - sgn(y); v = (s > 32767 || s < -32768); end
            4:  begin r = (x << n) & 'hFFFF; c = (n != 0) ? ((x >> (16 - n)) & 1) : 0; end
            5:  begin r = x >> n;            c = (n != 0) ? ((x >> (n - 1)) & 1) : 0; end
            6:  begin r = ((x << n) | (x >> (16 - n))) & 'hFFFF;
                      c = (n != 0) ? ((x >> (16 - n)) & 1) : 0; end
            7:  begin r = ((x >> n) | (x << (16 - n))) & 'hFFFF;
                      c = (n != 0) ? ((x >> (n - 1)) & 1) : 0; end
            8:  r = x & y;
            9:  r = x | y;
            10: r = x ^ y;
            11: r = ~(x | y) & 'hFFFF;
            12: r = ~(x & y) & 'hFFFF;
            13: r = (sgn(x) < sgn(y)) ? 1 : 0;
            14: r = (x == y) ? 1 : 0;
            15: r = (sgn(x) > sgn(y)) ? 1 : 0;
            default: r = 0;
        endcase
        f = (v << 3) | (c << 2) | (((r >> 15) & 1) << 1) | ((r == 0) ? 1 : 0);
    endfunction

    function automatic int latency(input int o, input int y);
        if (!BARREL && o >= 4 && o <= 7) return 1 + (y & 15);
        return 1;
    endfunction

    // Transaction-level model: idle, busy counting down, or holding a result
    bit m_valid = 0, m_busy = 0;
    int m_cnt = 0, m_res = 0, m_flags = 0, p_res = 0, p_flags = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 0; m_busy = 0; m_cnt = 0; m_res = 0; m_flags = 0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0; m_valid = 1; m_res = p_res; m_flags = p_flags;
            end
        end else if (in_valid) begin
            model(int'(op), int'(a), int'(b), p_res, p_flags);
            if (latency(int'(op), int'(b)) == 1) begin
                m_valid = 1; m_res = p_res; m_flags = p_flags;
            end else begin
                m_busy = 1; m_cnt = latency(int'(op), int'(b)) - 1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        check("in_ready",  in_ready,  32'(!(m_busy || m_valid)));
        check("out_valid", out_valid, 32'(m_valid));
        check("result",    result,    32'(m_res));
        check("flags",     flags,     32'(m_flags));
    end

    task automatic run_op(input string nm, input logic [3:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] er,
                          input logic [3:0] ef, input int lat);
        @(negedge clk);
        #1 op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check({nm, " out_valid"}, out_valid, 32'(k == lat));
            if (k == lat) begin
                check({nm, " result"}, result, er);
                check({nm, " flags"},  flags,  ef);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int r, f;
        logic [15:0] hold_r;
        logic [3:0]  hold_f;

        // Pin the reference model against hand-computed values
        model(2, 'h7FFF, 1, r, f);  check("model add r", r, 'h8000); check("model add f", f, 'hA);
        model(3, 3, 5, r, f);       check("model sub r", r, 'hFFFE); check("model sub f", f, 'h6);
        model(14, 'h1234, 'h1234, r, f); check("model eq r", r, 1);
        model(4, 'h8001, 4, r, f);  check("model shl r", r, 'h0010); check("model shl f", f, 0);
        model(7, 1, 1, r, f);       check("model rotr r", r, 'h8000); check("model rotr f", f, 'h6);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset flags", flags, 0);

        // First accept on the very first edge after reset release
        #1 reset = 1'b0; op = 4'h2; a = 16'h7FFF; b = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("first out_valid", out_valid, 1);
        check("first result", result, 16'h8000);
        check("first flags", flags, 4'hA);
        #1 in_valid = 1'b0;
        @(negedge clk);

        run_op("sub", 4'h3, 16'h0003, 16'h0005, 16'hFFFE, 4'h6, 1);
        run_op("eq",  4'hE, 16'h1234, 16'h1234, 16'h0001, 4'h0, 1);
        run_op("shl", 4'h4, 16'h8001, 16'h0004, 16'h0010, 4'h0, BARREL ? 1 : 5);
        run_op("rotr", 4'h7, 16'h0001, 16'h0001, 16'h8000, 4'h6, BARREL ? 1 : 2);
        run_op("shr0", 4'h5, 16'h8001, 16'h0010, 16'h8001, 4'h2, 1);

        // Randomized traffic with random back-pressure and one mid-run reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc == 1500) reset = 1'b1;
            if (cyc == 1502) reset = 1'b0;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: a = 16'h0000;
                1: a = 16'h8000;
                2: a = 16'h7FFF;
                3: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            b = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
        end

        #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Back-pressure in DONE: outputs hold, new requests are ignored
        #1 op = 4'h2; a = 16'h7FFF; b = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        hold_r = 16'h8000; hold_f = 4'hA;
        for (int k = 0; k < 3; k++) begin
            #1 op = 4'h1; a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            check("hold out_valid", out_valid, 1);
            check("hold in_ready", in_ready, 0);
            check("hold result", result, hold_r);
            check("hold flags", flags, hold_f);
        end
        #1 out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("release out_valid", out_valid, 0);
        check("release in_ready", in_ready, 1);
        check("idle keeps result", result, hold_r);

        // Reset during a long rotate aborts it
        #1 op = 4'h6; a = 16'h00F1; b = 16'h000F; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort result", result, 0);
        check("abort flags", flags, 0);
        check("abort in_ready", in_ready, 1);
        @(negedge clk);
        #1 reset = 1'b0; op = 4'h2; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        check("post-reset out_valid", out_valid, 1);
        check("post-reset result", result, 16'h0002);
        check("post-reset flags", flags, 4'h0);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
